// File: rtl/scan_reg_pkg.sv
// ---------------------------------------------------------------------------
// scan_reg_pkg
//   Shared constants and types for the scan control/status register bank.
//   Contents:
//     - geometry: segment count, CR/SR widths, SR field layout
//     - reg_state_t : request-handling FSM states
//     - reg_op_t    : latched operation kind
//     - reg_req_t   : request captured when the bank is idle
// ---------------------------------------------------------------------------
package scan_reg_pkg;

    localparam int NUM_SEG     = 4;
    localparam int SEG_W       = 2;
    localparam int CR_W        = 17;
    localparam int SR_W        = 15;

    // Status register layout: [14:8] write counter, [7:0] sticky flags.
    localparam int FLAG_LSB    = 0;
    localparam int FLAG_W      = 8;
    localparam int CNT_LSB     = 8;
    localparam int CNT_W       = 7;
    localparam int CNT_MAX     = 127;

    // In an SR write, this data bit requests a counter clear.
    localparam int CNT_CLR_BIT = 16;

    localparam int EVT_W       = NUM_SEG * FLAG_W;
    localparam int LAT_W       = 3;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } reg_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } reg_op_t;

    typedef struct packed {
        reg_op_t          op;
        logic             sel;    // 0 = CR, 1 = SR
        logic [SEG_W-1:0] seg;
        logic [CR_W-1:0]  wdata;
    } reg_req_t;

endpackage

// File: rtl/scan_sr_seg.sv
// ---------------------------------------------------------------------------
// scan_sr_seg
//   Status register for one segment. It holds 8 sticky event flags and a
//   7-bit saturating counter of CR writes.
//   Ports:
//     clk, rst_n : clock and asynchronous active-low reset
//     evt        : per-cycle event strobes; each one sets its flag
//     w1c_en     : apply w1c_mask as a write-1-to-clear this cycle
//     w1c_mask   : flags to clear
//     cnt_clr    : clear the counter
//     cnt_inc    : count one CR write, saturating at CNT_MAX
//     sr         : {counter, flags}
// ---------------------------------------------------------------------------
module scan_sr_seg
    import scan_reg_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLAG_W-1:0] evt,
    input  logic              w1c_en,
    input  logic [FLAG_W-1:0] w1c_mask,
    input  logic              cnt_clr,
    input  logic              cnt_inc,
    output logic [SR_W-1:0]   sr
);

    logic [FLAG_W-1:0] flags_q, flags_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first.
        // A missing branch would otherwise infer a latch.
        flags_d = flags_q;
        cnt_d   = cnt_q;

        if (w1c_en) begin
            flags_d = flags_d & ~w1c_mask;
        end
        // The OR is applied after the clear so that a hardware event wins
        // over a same-cycle W1C of the same bit.
        flags_d = flags_d | evt;

        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_inc && (cnt_q != CNT_W'(CNT_MAX))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    // Every register then samples pre-edge values, whatever the block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sr[CNT_LSB +: CNT_W]   = cnt_q;
    assign sr[FLAG_LSB +: FLAG_W] = flags_q;

endmodule

// File: rtl/scan_reg_bank.sv
// ---------------------------------------------------------------------------
// scan_reg_bank
//   Control/status register bank placed behind the group scan register
//   interface. It has four 17-bit control registers (CR), one per segment,
//   which drive the core through cr_out. It has four 15-bit status
//   registers (SR), each holding sticky event flags and a saturating
//   CR-write counter.
//
//   Each request is accepted in IDLE. It is completed ACK_LAT cycles later
//   with a one-cycle reg_ready pulse. Only one request is in flight at a
//   time. Requests that arrive while the bank is busy are dropped and are
//   not queued.
//
//   Parameters:
//     ACK_LAT : request-to-ready latency in cycles (legal range 1..7)
//     CR_RST  : reset value of every control register
//   Ports:
//     clk, rst_n        : clock and asynchronous active-low reset
//     reg_wen, reg_ren  : write/read strobes (a write wins if both are high)
//     seg_id, id_sel    : target segment; 0 = CR, 1 = SR
//     cr_wdata          : write data (CR value, or W1C mask and clear bit)
//     cr_rdata/sr_rdata : read data; each holds until the next read of its
//                         own type
//     reg_ready         : one-cycle completion pulse
//     hw_evt            : event strobes, byte s belongs to segment s
//     cr_out            : all CRs flattened, CR s at [17*s +: 17]
// ---------------------------------------------------------------------------
module scan_reg_bank
    import scan_reg_pkg::*;
#(
    parameter int              ACK_LAT = 2,
    parameter logic [CR_W-1:0] CR_RST  = 17'h00000
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    reg_wen,
    input  logic                    reg_ren,
    input  logic [SEG_W-1:0]        seg_id,
    input  logic                    id_sel,
    input  logic [CR_W-1:0]         cr_wdata,
    output logic [CR_W-1:0]         cr_rdata,
    output logic [SR_W-1:0]         sr_rdata,
    output logic                    reg_ready,
    input  logic [EVT_W-1:0]        hw_evt,
    output logic [NUM_SEG*CR_W-1:0] cr_out
);

    localparam logic [LAT_W-1:0] LAT = LAT_W'(ACK_LAT);

    reg_state_t       state_q;
    logic [LAT_W-1:0] cnt_q;
    reg_req_t         req_q;
    logic             ready_q;
    logic [CR_W-1:0]  cr_rdata_q;
    logic [SR_W-1:0]  sr_rdata_q;
    logic [CR_W-1:0]  cr_q [NUM_SEG];
    logic [SR_W-1:0]  sr_all [NUM_SEG];

    // The last BUSY cycle. Request effects are committed on this edge.
    logic done;
    assign done = (state_q == BUSY) && (cnt_q == LAT);

    // -----------------------------------------------------------------------
    // Request FSM, CR storage and read-data registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= '0;
            ready_q    <= 1'b0;
            cr_rdata_q <= '0;
            sr_rdata_q <= '0;
            // NOTE: the CR array is only four registers, and each one must
            // come out of reset at CR_RST. It is therefore reset explicitly,
            // unlike a RAM.
            for (int s = 0; s < NUM_SEG; s++) begin
                cr_q[s] <= CR_RST;
            end
        end else begin
            ready_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (reg_wen || reg_ren) begin
                        req_q.op    <= reg_wen ? OP_WRITE : OP_READ;
                        req_q.sel   <= id_sel;
                        req_q.seg   <= seg_id;
                        req_q.wdata <= cr_wdata;
                        cnt_q       <= LAT_W'(1);
                        state_q     <= BUSY;
                    end
                end

                BUSY: begin
                    if (cnt_q == LAT) begin
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        state_q <= ACK;
                        if (req_q.op == OP_WRITE) begin
                            // SR writes are committed inside scan_sr_seg.
                            if (!req_q.sel) begin
                                cr_q[req_q.seg] <= req_q.wdata;
                            end
                        end else if (!req_q.sel) begin
                            cr_rdata_q <= cr_q[req_q.seg];
                        end else begin
                            sr_rdata_q <= sr_all[req_q.seg];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ACK: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Per-segment status registers
    // -----------------------------------------------------------------------
    for (genvar s = 0; s < NUM_SEG; s++) begin : g_seg
        logic hit;
        logic sr_wr;
        logic cr_wr;

        assign hit   = done && (req_q.op == OP_WRITE) && (req_q.seg == SEG_W'(s));
        assign sr_wr = hit &&  req_q.sel;
        assign cr_wr = hit && !req_q.sel;

        scan_sr_seg u_sr (
            .clk      (clk),
            .rst_n    (rst_n),
            .evt      (hw_evt[FLAG_W*s +: FLAG_W]),
            .w1c_en   (sr_wr),
            .w1c_mask (req_q.wdata[FLAG_LSB +: FLAG_W]),
            .cnt_clr  (sr_wr && req_q.wdata[CNT_CLR_BIT]),
            .cnt_inc  (cr_wr),
            .sr       (sr_all[s])
        );

        assign cr_out[CR_W*s +: CR_W] = cr_q[s];
    end

    assign cr_rdata  = cr_rdata_q;
    assign sr_rdata  = sr_rdata_q;
    assign reg_ready = ready_q;

endmodule
